ldpc_frame_writer: RTL and testbench

- Write-side counterpart to the decoder's read address generation.
- Accepts a stream of channel LLRs over a valid/ready handshake and writes each frame into one of two ping-pong banks of the LLR memory, with addresses counting up from START_ADDR.
- Tracks per-bank fill state and hands complete frames to the decoder with a valid/ack handshake.
- Detects frame-length violations on the input stream.

---
 rtl/ldpc_frame_writer.sv | 166 ++++++++++++++++
 tb/tb_ldpc_frame_writer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_frame_writer.sv
// ldpc_frame_writer: writes an incoming LLR stream into two ping-pong banks
// of the LLR memory, tracks which banks hold complete frames and hands them
// to the decoder in commit order. Short and long frames are flagged and
// never exposed to the decoder.
module ldpc_frame_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 200,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_valid,
    output logic                  frame_bank,
    input  logic                  frame_ack,
    output logic                  frame_err,
    output logic [15:0]           frame_count
);

    localparam logic [ADDR_WIDTH-1:0] START_A  = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_WAIT_BANK = 2'd0,
        ST_WRITE     = 2'd1,
        ST_DROP      = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            bank_full_q, bank_full_d;
    logic                  commit_pend_q, commit_pend_d;
    logic                  commit_bank_q, commit_bank_d;
    logic                  wr_en_q, wr_en_d;
    logic                  wr_bank_q, wr_bank_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;
    logic [15:0]           frame_count_q, frame_count_d;

    logic accept;
    logic release_fire;

    assign in_ready     = ~reset & ((state_q == ST_WRITE) | (state_q == ST_DROP));
    assign accept       = in_valid & in_ready;
    assign release_fire = frame_ack & bank_full_q[rd_ptr_q];

    // Per-bank fill flag: set when a pending commit lands (one cycle after the
    // final write is issued), cleared when the decoder releases it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = (gi == 1);
            always_comb begin
                bank_full_d[gi] = (bank_full_q[gi] & ~(release_fire & (rd_ptr_q == BANK_ID)))
                                | (commit_pend_q & (commit_bank_q == BANK_ID));
            end
        end
    endgenerate

    // Writer FSM, write-port staging and commit bookkeeping.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q ^ release_fire;
        commit_pend_d = 1'b0;
        commit_bank_d = commit_bank_q;
        wr_en_d       = 1'b0;
        wr_bank_d     = wr_bank_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q + (commit_pend_q ? 16'd1 : 16'd0);

        case (state_q)
            ST_WAIT_BANK: begin
                // Bank flags already include this cycle's release.
                if (!bank_full_d[wr_ptr_q]) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_bank_d = wr_ptr_q;
                    wr_addr_d = START_A + idx_q;
                    wr_data_d = in_data;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (in_last) begin
                            commit_pend_d = 1'b1;
                            commit_bank_d = wr_ptr_q;
                            wr_ptr_d      = ~wr_ptr_q;
                            state_d       = bank_full_d[~wr_ptr_q] ? ST_WAIT_BANK : ST_WRITE;
                        end else begin
                            // Too long: discard the remainder up to in_last.
                            frame_err_d = 1'b1;
                            state_d     = ST_DROP;
                        end
                    end else if (in_last) begin
                        // Too short: restart the same bank from the top.
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (accept && in_last) state_d = ST_WRITE;
            end
            default: state_d = ST_WRITE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_WRITE;
            idx_q         <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            bank_full_q   <= 2'b00;
            commit_pend_q <= 1'b0;
            commit_bank_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_err_q   <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            bank_full_q   <= bank_full_d;
            commit_pend_q <= commit_pend_d;
            commit_bank_q <= commit_bank_d;
            wr_en_q       <= wr_en_d;
            wr_bank_q     <= wr_bank_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_bank     = wr_bank_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;
    assign frame_valid = bank_full_q[rd_ptr_q];
    assign frame_bank  = rd_ptr_q;

endmodule

// File: tb/tb_ldpc_frame_writer.sv
// Testbench for ldpc_frame_writer: expected memory writes are queued as beats
// are driven and compared as the DUT issues them; frame-level status is
// checked against a small behavioural model.
module tb_ldpc_frame_writer;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int FL = 4;
    localparam int SA = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_valid;
    logic          frame_bank;
    logic          frame_ack;
    logic          frame_err;
    logic [15:0]   frame_count;

    ldpc_frame_writer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL), .START_ADDR(SA)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_valid(frame_valid), .frame_bank(frame_bank), .frame_ack(frame_ack),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected writes: {bank, addr, data}
    logic [1+AW+DW-1:0] sb[$];

    // Model of the writer as seen from the stream side
    int   m_idx;
    logic m_ptr;
    bit   m_drop;
    int   exp_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Write-port monitor: every issued write must match the next expected one
    always @(negedge clk) begin
        if (!reset && wr_en) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", 32'({wr_bank, wr_addr, wr_data}), 32'hFFFF_FFFF);
            end else begin
                check("wr", 32'({wr_bank, wr_addr, wr_data}), 32'(sb.pop_front()));
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int   n;
        bit   acc;
        logic e_err;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n   = 0;
        acc = 0;
        while (!acc && n < 100) begin
            acc = in_ready;
            @(posedge clk);
            if (!acc) begin
                @(negedge clk);
                n++;
            end
        end
        if (!acc) begin
            check("accept_timeout", 32'(0), 32'(1));
            in_valid = 1'b0;
            return;
        end
        e_err = 1'b0;
        if (!m_drop) begin
            sb.push_back({m_ptr, AW'(SA + m_idx), d});
            if (m_idx == FL - 1) begin
                m_idx = 0;
                if (last) begin
                    m_ptr = ~m_ptr;
                    exp_count++;
                end else begin
                    e_err  = 1'b1;
                    m_drop = 1'b1;
                end
            end else if (last) begin
                e_err = 1'b1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end else if (last) begin
            m_drop = 1'b0;
        end
        #1;
        check("frame_err", 32'(frame_err), 32'(e_err));
    endtask

    task automatic send_frame(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) send_beat(base + DW'(i), i == n - 1);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        frame_ack = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_outs", 32'({wr_en, wr_bank, wr_addr, wr_data, frame_valid, frame_bank, frame_err}), 32'(0));
        check("rst_count", 32'(frame_count), 32'(0));
        check("rst_sb_drained", 32'(sb.size()), 32'(0));
        sb.delete();
        m_idx = 0; m_ptr = 1'b0; m_drop = 1'b0; exp_count = 0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'(1));
    endtask

    task automatic check_status(input string tag, input logic v, input logic b);
        check({tag, "_valid"}, 32'(frame_valid), 32'(v));
        if (v) check({tag, "_bank"}, 32'(frame_bank), 32'(b));
        check({tag, "_count"}, 32'(frame_count), 32'(exp_count));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; frame_ack = 1'b0;
        m_idx = 0; m_ptr = 1'b0; m_drop = 1'b0; exp_count = 0;

        // Basic frame, back-to-back, with commit timing
        do_reset();
        send_frame(FL, 8'd1);
        idle();
        check("t1_last_wr_en", 32'(wr_en), 32'(1));
        check("t1_valid_early", 32'(frame_valid), 32'(0));
        @(negedge clk);
        check("t1_wr_en_off", 32'(wr_en), 32'(0));
        check_status("t1", 1'b1, 1'b0);

        // Two full frames fill both banks; ack frees bank 0 for frame 3
        do_reset();
        send_frame(FL, 8'h10);
        send_frame(FL, 8'h20);
        idle();
        check("t2_ready_drop", 32'(in_ready), 32'(0));
        repeat (2) @(negedge clk);
        check("t2_ready_held", 32'(in_ready), 32'(0));
        check_status("t2a", 1'b1, 1'b0);
        pulse_ack();
        check_status("t2b", 1'b1, 1'b1);
        @(negedge clk);
        check("t2_ready_back", 32'(in_ready), 32'(1));
        send_frame(FL, 8'h30);
        idle();
        repeat (2) @(negedge clk);
        check_status("t2c", 1'b1, 1'b1);
        check("t2_ready_full", 32'(in_ready), 32'(0));

        // Short frame then a good frame
        do_reset();
        send_frame(2, 8'h40);
        idle();
        repeat (2) @(negedge clk);
        check_status("t3a", 1'b0, 1'b0);
        send_frame(FL, 8'h50);
        idle();
        repeat (2) @(negedge clk);
        check_status("t3b", 1'b1, 1'b0);

        // Long frame: excess beats dropped, then a good frame
        do_reset();
        send_frame(6, 8'h60);
        idle();
        repeat (2) @(negedge clk);
        check_status("t4a", 1'b0, 1'b0);
        send_frame(FL, 8'h70);
        idle();
        repeat (2) @(negedge clk);
        check_status("t4b", 1'b1, 1'b0);

        // Ack with nothing to release
        do_reset();
        pulse_ack();
        check_status("t5a", 1'b0, 1'b0);
        send_frame(FL, 8'h80);
        idle();
        repeat (2) @(negedge clk);
        check_status("t5b", 1'b1, 1'b0);

        // Reset mid-frame with bank 1 full
        do_reset();
        send_frame(FL, 8'h90);
        idle();
        pulse_ack();
        send_frame(FL, 8'hA0);
        idle();
        repeat (2) @(negedge clk);
        check_status("t6a", 1'b1, 1'b1);
        send_beat(8'hB0, 1'b0);
        send_beat(8'hB1, 1'b0);
        idle();
        do_reset();
        send_frame(FL, 8'hC0);
        idle();
        repeat (2) @(negedge clk);
        check_status("t6b", 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("final_sb_drained", 32'(sb.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
